cmo_req_arbiter: RTL and testbench

- Shares the single L1 D-cache CMO request/response port between NR_PORTS requesters, e.g. port 0 = CMO functional unit, port 1 = fence/flush-all engine.
- Round-robin arbitration with grant lock until the cache accepts the request.
- Tracks outstanding CMOs in acceptance order and routes each cache ack back to the originating requester.
- Sits between the requesters and the D-cache CMO interface.

---
 rtl/cmo_req_arbiter_pkg.sv | 41 ++++
 rtl/cmo_req_arbiter_fifo.sv | 67 ++++++
 rtl/cmo_req_arbiter.sv | 132 +++++++++++++
 tb/tb_cmo_req_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmo_req_arbiter_pkg.sv
// Shared CMO request/response types and arbiter definitions used by the
// D-cache CMO port arbiter and its outstanding-request tracker.
package cmo_req_arbiter_pkg;

    localparam int unsigned CMO_ARB_MAX_PORTS = 8;
    localparam int unsigned CMO_TRANS_ID_W    = 4;
    localparam int unsigned CMO_ADDR_W        = 64;

    typedef enum logic [3:0] {
        CMO_CLEAN = 4'd0,
        CMO_FLUSH = 4'd1,
        CMO_INVAL = 4'd2,
        CMO_ZERO  = 4'd3
    } cmo_t;

    typedef struct packed {
        logic                      req;
        logic [CMO_ADDR_W-1:0]     address;
        cmo_t                      cmo_op;
        logic [CMO_TRANS_ID_W-1:0] trans_id;
    } cmo_req_t;

    typedef struct packed {
        logic                      req_ready;
        logic                      ack;
        logic [CMO_TRANS_ID_W-1:0] trans_id;
    } cmo_resp_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } cmo_arb_state_t;

    // Modular increment used for the round-robin search and pointer update.
    function automatic int unsigned cmo_arb_wrap(input int unsigned base,
                                                 input int unsigned offset,
                                                 input int unsigned n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/cmo_req_arbiter_fifo.sv
// In-order FIFO of requester indices, one entry per CMO accepted by the
// cache and not yet acknowledged.
module cmo_outstanding_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cmo_req_arbiter.sv
// Round-robin arbiter sharing the D-cache CMO port between requesters, with
// grant lock until accept and in-order routing of cache acks back to origin.
module cmo_req_arbiter
    import cmo_req_arbiter_pkg::*;
#(
    parameter int unsigned NR_PORTS        = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  cmo_req_t                           req_i [NR_PORTS],
    output cmo_resp_t                          resp_o [NR_PORTS],
    output cmo_req_t                           dc_req_o,
    input  cmo_resp_t                          dc_resp_i,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               spurious_ack_o
);
    localparam int unsigned PORT_W = $clog2(NR_PORTS);

    cmo_arb_state_t    state_q, state_d;
    logic [PORT_W-1:0] grant_q, grant_d;
    logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;
    logic              spurious_q, spurious_d;

    logic [PORT_W-1:0] rr_idx, cand_idx, act_idx, head_idx;
    int unsigned       cand;
    logic              rr_found, act_valid, accept;
    logic              fifo_full, fifo_empty, fifo_pop;

    // First requesting port at or after the round-robin pointer.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = rr_ptr_q;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            cand     = cmo_arb_wrap(32'(rr_ptr_q), i, NR_PORTS);
            cand_idx = PORT_W'(cand);
            if (!rr_found && req_i[cand_idx].req) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx;
            end
        end
    end

    // A full FIFO blocks issue based on registered occupancy only, so a
    // same-cycle ack never opens a combinational path into the request side.
    always_comb begin
        if (state_q == ARB_LOCKED) begin
            act_idx   = grant_q;
            act_valid = req_i[grant_q].req & ~fifo_full;
        end else begin
            act_idx   = rr_idx;
            act_valid = rr_found & ~fifo_full;
        end
        accept = act_valid & dc_resp_i.req_ready;
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        spurious_d = spurious_q | (dc_resp_i.ack & fifo_empty);
        if (accept) begin
            rr_ptr_d = PORT_W'(cmo_arb_wrap(32'(act_idx), 1, NR_PORTS));
        end
        case (state_q)
            ARB_IDLE: begin
                if (act_valid && !dc_resp_i.req_ready) begin
                    state_d = ARB_LOCKED;
                    grant_d = act_idx;
                end
            end
            ARB_LOCKED: begin
                if (!req_i[grant_q].req || accept) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // The granted port only sees req_ready when its request is actually taken.
    always_comb begin
        dc_req_o = '0;
        if (state_q == ARB_LOCKED || act_valid) begin
            dc_req_o     = req_i[act_idx];
            dc_req_o.req = act_valid;
        end
        fifo_pop = dc_resp_i.ack & ~fifo_empty;
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            resp_o[p]           = '0;
            resp_o[p].req_ready = accept && (act_idx == PORT_W'(p));
            resp_o[p].ack       = fifo_pop && (head_idx == PORT_W'(p));
            if (resp_o[p].ack) begin
                resp_o[p].trans_id = dc_resp_i.trans_id;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            spurious_q <= spurious_d;
        end
    end

    assign spurious_ack_o = spurious_q;

    cmo_outstanding_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (PORT_W)
    ) i_outstanding_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .data_i  (act_idx),
        .pop_i   (fifo_pop),
        .data_o  (head_idx),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

endmodule

// File: tb/tb_cmo_req_arbiter.sv
// Self-checking bench for cmo_req_arbiter: hand-derived vector table, directed
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_cmo_req_arbiter;
    import cmo_req_arbiter_pkg::*;

    localparam int unsigned N    = 2;
    localparam int unsigned MAXO = 4;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    cmo_req_t  req_i [N];
    cmo_resp_t resp_o [N];
    cmo_req_t  dc_req_o;
    cmo_resp_t dc_resp_i;
    logic [2:0] outstanding_o;
    logic      spurious_ack_o;

    cmo_req_arbiter #(
        .NR_PORTS        (N),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_i          (req_i),
        .resp_o         (resp_o),
        .dc_req_o       (dc_req_o),
        .dc_resp_i      (dc_resp_i),
        .outstanding_o  (outstanding_o),
        .spurious_ack_o (spurious_ack_o)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] port_addr [N];
    logic [3:0]  port_id   [N];
    cmo_t        port_op   [N];

    // Reference model: outstanding requesters in acceptance order, fairness
    // pointer, lock holder and the sticky spurious flag.
    int model_q[$];
    int model_rr;
    bit model_locked;
    int model_lock_port;
    bit model_spur;

    typedef struct {
        logic [1:0] req;
        logic       ready;
        logic       ack;
        logic [3:0] ack_id;
        logic       exp_req;
        int         exp_port;
        logic [1:0] exp_ack;
        int         exp_out;
        logic       exp_spur;
    } vec_t;

    vec_t vecs [17];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        model_rr        = 0;
        model_locked    = 1'b0;
        model_lock_port = 0;
        model_spur      = 1'b0;
    endtask

    task automatic driveIdle();
        for (int p = 0; p < N; p++) begin
            req_i[p] = '0;
        end
        dc_resp_i = '0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        driveIdle();
        #1;
        checkOutput("rst_dc_req", 64'(dc_req_o.req), 64'(0));
        checkOutput("rst_outstanding", 64'(outstanding_o), 64'(0));
        checkOutput("rst_spurious", 64'(spurious_ack_o), 64'(0));
        checkOutput("rst_resp", 64'({resp_o[1], resp_o[0]}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    task automatic applyStimulus(input logic [1:0] req_mask, input logic ready,
                                 input logic ack, input logic [3:0] ack_id);
        int g;
        int ack_port;
        bit full;
        bit valid;
        bit accept;
        @(negedge clk);
        for (int p = 0; p < N; p++) begin
            req_i[p].req      = req_mask[p];
            req_i[p].address  = port_addr[p];
            req_i[p].cmo_op   = port_op[p];
            req_i[p].trans_id = port_id[p];
        end
        dc_resp_i.req_ready = ready;
        dc_resp_i.ack       = ack;
        dc_resp_i.trans_id  = ack_id;
        #1;
        full = (model_q.size() == MAXO);
        g = -1;
        if (model_locked) begin
            g = model_lock_port;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_mask[(model_rr + k) % N]) g = (model_rr + k) % N;
            end
        end
        valid = 1'b0;
        if (g >= 0) valid = req_mask[g] && !full;
        accept   = valid && ready;
        ack_port = (ack && model_q.size() > 0) ? model_q[0] : -1;

        checkOutput("dc_req", 64'(dc_req_o.req), 64'(valid));
        if (valid) begin
            checkOutput("dc_addr", dc_req_o.address, port_addr[g]);
            checkOutput("dc_id", 64'(dc_req_o.trans_id), 64'(port_id[g]));
            checkOutput("dc_op", 64'(dc_req_o.cmo_op), 64'(port_op[g]));
        end
        for (int p = 0; p < N; p++) begin
            checkOutput($sformatf("resp%0d_ready", p), 64'(resp_o[p].req_ready), 64'(accept && p == g));
            checkOutput($sformatf("resp%0d_ack", p), 64'(resp_o[p].ack), 64'(p == ack_port));
            if (p == ack_port) begin
                checkOutput($sformatf("resp%0d_id", p), 64'(resp_o[p].trans_id), 64'(ack_id));
            end
        end
        checkOutput("outstanding", 64'(outstanding_o), 64'(model_q.size()));
        checkOutput("spurious", 64'(spurious_ack_o), 64'(model_spur));

        if (ack) begin
            if (model_q.size() > 0) void'(model_q.pop_front());
            else model_spur = 1'b1;
        end
        if (accept) begin
            model_q.push_back(g);
            model_rr = (g + 1) % N;
        end
        if (model_locked) begin
            if (!req_mask[g] || accept) model_locked = 1'b0;
        end else if (valid && !ready) begin
            model_locked    = 1'b1;
            model_lock_port = g;
        end
    endtask

    initial begin
        driveIdle();
        for (int p = 0; p < N; p++) begin
            port_addr[p] = 64'hA000 + 64'(p) * 64'h100;
            port_id[p]   = 4'(p + 1);
            port_op[p]   = cmo_t'(4'(p));
        end
        modelReset();

        vecs[0]  = '{2'b01, 1'b1, 1'b0, 4'd0, 1'b1, 0, 2'b00, 0, 1'b0};
        vecs[1]  = '{2'b01, 1'b1, 1'b0, 4'd0, 1'b1, 0, 2'b00, 1, 1'b0};
        vecs[2]  = '{2'b01, 1'b1, 1'b1, 4'd1, 1'b1, 0, 2'b01, 2, 1'b0};
        vecs[3]  = '{2'b11, 1'b1, 1'b0, 4'd0, 1'b1, 1, 2'b00, 2, 1'b0};
        vecs[4]  = '{2'b11, 1'b1, 1'b0, 4'd0, 1'b1, 0, 2'b00, 3, 1'b0};
        vecs[5]  = '{2'b11, 1'b1, 1'b1, 4'd5, 1'b0, 0, 2'b01, 4, 1'b0};
        vecs[6]  = '{2'b11, 1'b1, 1'b0, 4'd0, 1'b1, 1, 2'b00, 3, 1'b0};
        vecs[7]  = '{2'b00, 1'b1, 1'b1, 4'd2, 1'b0, 0, 2'b01, 4, 1'b0};
        vecs[8]  = '{2'b00, 1'b1, 1'b1, 4'd3, 1'b0, 0, 2'b10, 3, 1'b0};
        vecs[9]  = '{2'b00, 1'b1, 1'b1, 4'd4, 1'b0, 0, 2'b01, 2, 1'b0};
        vecs[10] = '{2'b00, 1'b1, 1'b1, 4'd5, 1'b0, 0, 2'b10, 1, 1'b0};
        vecs[11] = '{2'b00, 1'b1, 1'b1, 4'd6, 1'b0, 0, 2'b00, 0, 1'b0};
        vecs[12] = '{2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 0, 2'b00, 0, 1'b1};
        vecs[13] = '{2'b10, 1'b0, 1'b0, 4'd0, 1'b1, 1, 2'b00, 0, 1'b1};
        vecs[14] = '{2'b11, 1'b0, 1'b0, 4'd0, 1'b1, 1, 2'b00, 0, 1'b1};
        vecs[15] = '{2'b11, 1'b1, 1'b0, 4'd0, 1'b1, 1, 2'b00, 0, 1'b1};
        vecs[16] = '{2'b11, 1'b1, 1'b0, 4'd0, 1'b1, 0, 2'b00, 1, 1'b1};

        doReset();
        $display("[TB] vector table");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].req, vecs[i].ready, vecs[i].ack, vecs[i].ack_id);
            checkOutput($sformatf("tbl%0d_req", i), 64'(dc_req_o.req), 64'(vecs[i].exp_req));
            if (vecs[i].exp_req) begin
                checkOutput($sformatf("tbl%0d_addr", i), dc_req_o.address, port_addr[vecs[i].exp_port]);
            end
            checkOutput($sformatf("tbl%0d_ack", i), 64'({resp_o[1].ack, resp_o[0].ack}), 64'(vecs[i].exp_ack));
            for (int p = 0; p < N; p++) begin
                if (vecs[i].exp_ack[p]) begin
                    checkOutput($sformatf("tbl%0d_ackid", i), 64'(resp_o[p].trans_id), 64'(vecs[i].ack_id));
                end
            end
            checkOutput($sformatf("tbl%0d_out", i), 64'(outstanding_o), 64'(vecs[i].exp_out));
            checkOutput($sformatf("tbl%0d_spur", i), 64'(spurious_ack_o), 64'(vecs[i].exp_spur));
        end

        $display("[TB] single port, three CMOs");
        doReset();
        for (int k = 1; k <= 3; k++) begin
            port_id[0] = 4'(k);
            applyStimulus(2'b01, 1'b1, 1'b0, 4'd0);
            checkOutput("sp_accept", 64'(resp_o[0].req_ready), 64'(1));
        end
        applyStimulus(2'b00, 1'b1, 1'b0, 4'd0);
        checkOutput("sp_peak", 64'(outstanding_o), 64'(3));
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(2'b00, 1'b1, 1'b1, 4'(k));
            checkOutput("sp_ack0", 64'(resp_o[0].ack), 64'(1));
            checkOutput("sp_ackid", 64'(resp_o[0].trans_id), 64'(k));
            checkOutput("sp_ack1", 64'(resp_o[1].ack), 64'(0));
        end

        $display("[TB] round-robin fairness");
        doReset();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(2'b11, 1'b1, k > 0, 4'(k));
            checkOutput($sformatf("rr_grant%0d", k), 64'(resp_o[k % 2].req_ready), 64'(1));
        end

        $display("[TB] grant lock");
        doReset();
        for (int k = 0; k < 5; k++) begin
            applyStimulus((k >= 2) ? 2'b11 : 2'b10, 1'b0, 1'b0, 4'd0);
            checkOutput($sformatf("lock_addr%0d", k), dc_req_o.address, port_addr[1]);
        end
        applyStimulus(2'b11, 1'b1, 1'b0, 4'd0);
        checkOutput("lock_accept1", 64'(resp_o[1].req_ready), 64'(1));
        applyStimulus(2'b01, 1'b1, 1'b0, 4'd0);
        checkOutput("lock_accept0", 64'(resp_o[0].req_ready), 64'(1));

        $display("[TB] out-of-port ordering");
        doReset();
        port_id[1] = 4'd7;
        port_id[0] = 4'd9;
        applyStimulus(2'b10, 1'b1, 1'b0, 4'd0);
        applyStimulus(2'b01, 1'b1, 1'b0, 4'd0);
        applyStimulus(2'b00, 1'b0, 1'b1, 4'd7);
        checkOutput("ord_first", 64'({resp_o[1].ack, resp_o[0].ack}), 64'(2'b10));
        applyStimulus(2'b00, 1'b0, 1'b1, 4'd9);
        checkOutput("ord_second", 64'({resp_o[1].ack, resp_o[0].ack}), 64'(2'b01));
        checkOutput("ord_id", 64'(resp_o[0].trans_id), 64'(9));

        $display("[TB] reset with outstanding CMOs");
        doReset();
        applyStimulus(2'b01, 1'b1, 1'b0, 4'd0);
        applyStimulus(2'b01, 1'b1, 1'b0, 4'd0);
        doReset();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(2'b00, 1'b0, 1'b1, 4'(k + 1));
            checkOutput("spur_noack", 64'({resp_o[1].ack, resp_o[0].ack}), 64'(0));
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b00, 1'b0, 1'b0, 4'd0);
            checkOutput("spur_sticky", 64'(spurious_ack_o), 64'(1));
        end

        $display("[TB] randomized traffic");
        doReset();
        for (int c = 0; c < 600; c++) begin
            logic [1:0] mask;
            logic       rdy;
            logic       ack;
            if (c == 300) doReset();
            for (int p = 0; p < N; p++) begin
                port_addr[p] = {$urandom, $urandom};
                port_id[p]   = 4'($urandom_range(0, 15));
                port_op[p]   = cmo_t'(4'($urandom_range(0, 3)));
            end
            mask = 2'($urandom_range(0, 3));
            if (model_locked && $urandom_range(0, 9) != 0) mask[model_lock_port] = 1'b1;
            rdy = ($urandom_range(0, 3) != 0);
            ack = (model_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
            applyStimulus(mask, rdy, ack, 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
